axi_read_arbiter: RTL and testbench

Shares the single AXI4 read port between the instruction cache (requester 0, behind the instruction fetcher) and the data cache (requester 1). Each requester sees a private AR/R channel pair. The arbiter grants whole bursts, from AR acceptance through the final R beat, using round-robin priority. It sits between the two cache instances and the top-level `m_axi_*` read pins; write channels are not routed through it.

---
 rtl/axi_read_arbiter.sv | 154 +++++++++++++++
 tb/tb_axi_read_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - round-robin burst arbiter sharing one AXI4 read port between two requesters
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic                  s0_rlast,

  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic                  s1_rlast,

  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rlast,

  output logic                  busy,
  output logic                  grant_id,
  output logic                  rlast_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                state;
  logic                  last_grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [8:0]            beat_cnt;

  logic                  idle_ok;
  logic                  s0_win;
  logic                  s1_win;
  logic                  in_data;
  logic                  owner_rready;
  logic                  r_hs;
  logic                  cnt_at_len;

  // Grants are only offered while idle and out of reset, so arready never pulses mid-burst.
  assign idle_ok = (state == IDLE) && !reset;
  assign s0_win  = idle_ok && s0_arvalid && (!s1_arvalid || last_grant);
  assign s1_win  = idle_ok && s1_arvalid && !s0_win;

  assign s0_arready = s0_win;
  assign s1_arready = s1_win;

  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = size_q;
  assign m_axi_arburst = burst_q;

  // R channel is a pure combinational steer towards the burst owner.
  assign in_data      = (state == DATA);
  assign owner_rready = grant_id ? s1_rready : s0_rready;
  assign m_axi_rready = in_data && owner_rready;
  assign r_hs         = m_axi_rvalid && m_axi_rready;
  assign cnt_at_len   = (beat_cnt == {1'b0, len_q});

  assign s0_rvalid = in_data && !grant_id && m_axi_rvalid;
  assign s0_rdata  = (in_data && !grant_id) ? m_axi_rdata : '0;
  assign s0_rlast  = in_data && !grant_id && m_axi_rlast;

  assign s1_rvalid = in_data && grant_id && m_axi_rvalid;
  assign s1_rdata  = (in_data && grant_id) ? m_axi_rdata : '0;
  assign s1_rlast  = in_data && grant_id && m_axi_rlast;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      grant_id      <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      beat_cnt      <= '0;
      rlast_err     <= 1'b0;
      busy          <= 1'b0;
      m_axi_arvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s0_win || s1_win) begin
            addr_q        <= s1_win ? s1_araddr  : s0_araddr;
            len_q         <= s1_win ? s1_arlen   : s0_arlen;
            size_q        <= s1_win ? s1_arsize  : s0_arsize;
            burst_q       <= s1_win ? s1_arburst : s0_arburst;
            grant_id      <= s1_win;
            last_grant    <= s1_win;
            beat_cnt      <= '0;
            busy          <= 1'b1;
            m_axi_arvalid <= 1'b1;
            state         <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            state         <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 9'd1;
            // Flag rlast arriving early, or the expected last beat arriving without it.
            if (m_axi_rlast != cnt_at_len) begin
              rlast_err <= 1'b1;
            end
            if (m_axi_rlast) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          busy          <= 1'b0;
          m_axi_arvalid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - randomized self-checking bench for axi_read_arbiter with a burst-level reference model
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;

  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
  logic [63:0] s0_araddr, s0_rdata;
  logic [7:0]  s0_arlen;
  logic [2:0]  s0_arsize;
  logic [1:0]  s0_arburst;

  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
  logic [63:0] s1_araddr, s1_rdata;
  logic [7:0]  s1_arlen;
  logic [2:0]  s1_arsize;
  logic [1:0]  s1_arburst;

  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [63:0] m_axi_araddr, m_axi_rdata;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;

  logic        busy, grant_id, rlast_err;

  int compared = 0;
  int fails    = 0;

  // Reference model state: pending requests per requester, who was served last, sticky error.
  bit [1:0]    pend;
  logic [63:0] raddr  [2];
  logic [7:0]  rlen   [2];
  logic [2:0]  rsize  [2];
  logic [1:0]  rburst [2];
  bit          last_served;
  bit          exp_err;

  always #5 clk = ~clk;

  axi_read_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
    .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rlast(s0_rlast),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
    .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rlast(s1_rlast),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rlast(m_axi_rlast),
    .busy(busy), .grant_id(grant_id), .rlast_err(rlast_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_data(input logic [63:0] a, input int i);
    return (a * 64'd3) ^ (64'(i) * 64'h0101_0101_0101_0101) ^ 64'hDEAD_0000_0000_0000;
  endfunction

  task automatic drive_req();
    s0_arvalid = pend[0]; s0_araddr = raddr[0]; s0_arlen = rlen[0];
    s0_arsize  = rsize[0]; s0_arburst = rburst[0];
    s1_arvalid = pend[1]; s1_araddr = raddr[1]; s1_arlen = rlen[1];
    s1_arsize  = rsize[1]; s1_arburst = rburst[1];
  endtask

  task automatic new_req(input int r);
    pend[r]   = 1'b1;
    raddr[r]  = {$urandom, $urandom} & ~64'h7;
    rlen[r]   = 8'($urandom_range(0, 15));
    rsize[r]  = 3'd3;
    rburst[r] = 2'd1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_m_arvalid"}, m_axi_arvalid, 0);
    chk({tag, "_m_rready"},  m_axi_rready, 0);
    chk({tag, "_m_araddr"},  m_axi_araddr, 0);
    chk({tag, "_m_arlen"},   m_axi_arlen, 0);
    chk({tag, "_m_arsize"},  m_axi_arsize, 0);
    chk({tag, "_m_arburst"}, m_axi_arburst, 0);
    chk({tag, "_s0_arready"}, s0_arready, 0);
    chk({tag, "_s1_arready"}, s1_arready, 0);
    chk({tag, "_s0_rvalid"}, s0_rvalid, 0);
    chk({tag, "_s1_rvalid"}, s1_rvalid, 0);
    chk({tag, "_s0_rdata"},  s0_rdata, 0);
    chk({tag, "_s1_rdata"},  s1_rdata, 0);
    chk({tag, "_s0_rlast"},  s0_rlast, 0);
    chk({tag, "_s1_rlast"},  s1_rlast, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_grant_id"},  grant_id, 0);
    chk({tag, "_rlast_err"}, rlast_err, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pend = 2'b00;
    drive_req();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_arready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    last_served = 1'b1;
    exp_err = 1'b0;
    #2;
    check_zero("reset");
    tick();
  endtask

  // One full burst: arbitration, AR phase with optional stall, then the R beats from a memory model.
  // mode 0: no backpressure, 1: random valid/ready, 2: owner rready low 2 cycles at beat 3.
  task automatic serve_one(input int stall, input int mode, input int bad_last,
                           input int abort_after, input bit rearm);
    bit          w;
    logic [63:0] ea;
    logic [7:0]  el;
    logic [2:0]  es;
    logic [1:0]  eb;
    int          lb, i, guard, hold;
    bit          done, rv, rr;
    drive_req();
    #1;
    w = (pend[0] && pend[1]) ? !last_served : !pend[0];
    chk("idle_busy", busy, 0);
    chk("arready_winner", w ? s1_arready : s0_arready, 1);
    chk("arready_loser",  w ? s0_arready : s1_arready, 0);
    ea = raddr[w]; el = rlen[w]; es = rsize[w]; eb = rburst[w];
    tick();
    last_served = w;
    if (rearm) new_req(int'(w)); else pend[w] = 1'b0;
    drive_req();
    for (int k = 0; k <= stall; k++) begin
      m_axi_arready = (k == stall);
      m_axi_rvalid  = 1'b1;
      m_axi_rlast   = 1'b1;
      s0_rready = 1'b1; s1_rready = 1'b1;
      #2;
      chk("addr_arvalid", m_axi_arvalid, 1);
      chk("addr_araddr",  m_axi_araddr, ea);
      chk("addr_arlen",   m_axi_arlen, el);
      chk("addr_arsize",  m_axi_arsize, es);
      chk("addr_arburst", m_axi_arburst, eb);
      chk("addr_grant",   grant_id, w);
      chk("addr_busy",    busy, 1);
      chk("addr_stray_rready", m_axi_rready, 0);
      chk("addr_stray_rvalid", s0_rvalid | s1_rvalid, 0);
      tick();
    end
    m_axi_arready = 1'b0;
    lb = (bad_last >= 0) ? bad_last : int'(el);
    i = 0; done = 1'b0; guard = 0; hold = 0;
    while (!done && guard < 400) begin
      guard++;
      case (mode)
        1:       begin rv = ($urandom % 4) != 0; rr = ($urandom % 3) != 0; end
        2:       begin rv = 1'b1; rr = !(i == 3 && hold < 2); if (!rr) hold++; end
        default: begin rv = 1'b1; rr = 1'b1; end
      endcase
      m_axi_rvalid = rv;
      m_axi_rdata  = beat_data(ea, i);
      m_axi_rlast  = (i == lb);
      if (w) begin s1_rready = rr; s0_rready = 1'($urandom); end
      else   begin s0_rready = rr; s1_rready = 1'($urandom); end
      #2;
      chk("data_rlast_err", rlast_err, exp_err);
      chk("data_owner_rvalid", w ? s1_rvalid : s0_rvalid, rv);
      chk("data_other_rvalid", w ? s0_rvalid : s1_rvalid, 0);
      chk("data_other_rdata",  w ? s0_rdata  : s1_rdata, 0);
      chk("data_other_rlast",  w ? s0_rlast  : s1_rlast, 0);
      chk("data_m_rready", m_axi_rready, rr);
      if (rv) begin
        chk("data_owner_rdata", w ? s1_rdata : s0_rdata, beat_data(ea, i));
        chk("data_owner_rlast", w ? s1_rlast : s0_rlast, (i == lb));
      end
      if (rv && rr) begin
        if ((i == lb) != (i == int'(el))) exp_err = 1'b1;
        if (i == lb) done = 1'b1;
        i++;
      end
      tick();
      if (abort_after >= 0 && i == abort_after && !done) begin
        m_axi_rvalid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_served = 1'b1;
        exp_err = 1'b0;
        pend = 2'b00;
        drive_req();
        #2;
        check_zero("abort");
        return;
      end
    end
    chk("burst_completed", done, 1);
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    #1;
    chk("post_burst_busy", busy, 0);
    chk("post_burst_rlast_err", rlast_err, exp_err);
  endtask

  initial begin
    pend = 2'b00;
    for (int r = 0; r < 2; r++) begin
      raddr[r] = '0; rlen[r] = '0; rsize[r] = '0; rburst[r] = '0;
    end
    s0_rready = 1'b0; s1_rready = 1'b0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0;
    do_reset();

    // Single s0 burst with fixed payload.
    pend[0] = 1'b1; raddr[0] = 64'h1000; rlen[0] = 8'd7; rsize[0] = 3'd3; rburst[0] = 2'd1;
    serve_one(0, 0, -1, -1, 1'b0);

    // Tie after reset, then continuous requesters alternate, then drain.
    do_reset();
    new_req(0); new_req(1);
    for (int n = 0; n < 5; n++) serve_one(0, 0, -1, -1, 1'b1);
    serve_one(0, 0, -1, -1, 1'b0);
    serve_one(0, 0, -1, -1, 1'b0);

    // AR backpressure: three stalled cycles.
    new_req(0);
    serve_one(3, 0, -1, -1, 1'b0);

    // R backpressure on s1 mid-burst.
    new_req(1); rlen[1] = 8'd7;
    serve_one(0, 2, -1, -1, 1'b0);

    // Single-beat burst.
    new_req(0); rlen[0] = 8'd0;
    serve_one(0, 0, -1, -1, 1'b0);

    // Early rlast: arlen 3 with rlast on beat 2; flag must stay set across a clean burst.
    new_req(0); rlen[0] = 8'd3;
    serve_one(0, 0, 1, -1, 1'b0);
    chk("err_early_set", rlast_err, 1);
    new_req(1);
    serve_one(0, 0, -1, -1, 1'b0);
    chk("err_sticky", rlast_err, 1);
    do_reset();

    // Late rlast: arlen 1, rlast only on the third beat.
    new_req(1); rlen[1] = 8'd1;
    serve_one(0, 0, 2, -1, 1'b0);
    chk("err_late_set", rlast_err, 1);
    do_reset();

    // Reset after beat 3 of 8, then a fresh s1 request.
    new_req(0); rlen[0] = 8'd7;
    serve_one(0, 0, -1, 3, 1'b0);
    new_req(1);
    serve_one(0, 0, -1, -1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if (!pend[0] && ($urandom % 2)) new_req(0);
      if (!pend[1] && ($urandom % 2)) new_req(1);
      if (pend == 2'b00) new_req(int'($urandom % 2));
      serve_one(int'($urandom % 3), 1, -1, -1, 1'($urandom));
    end
    while (pend != 2'b00) serve_one(0, 1, -1, -1, 1'b0);
    chk("random_no_err", rlast_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end

endmodule
